// File: rtl/spi_rdback_mon_if.sv
// Bundle between the SPI master tap and the read-back monitor: SPI pins in,
// decoded frame, status flags and shadow read port out.
interface spi_rdback_mon_if;
  logic       spi_cs;
  logic       spi_sdi;
  logic       spi_sdo;
  logic       spi_rdy;
  logic       frm_vld;
  logic       frm_rw;
  logic [6:0] frm_addr;
  logic [7:0] frm_data;
  logic [7:0] frm_cnt;
  logic       ver_ok;
  logic       ver_err;
  logic       short_err;
  logic       cfg_ok;
  logic [2:0] shd_addr;
  logic [7:0] shd_data;

  modport master (
    output spi_cs, spi_sdi, spi_sdo, spi_rdy, shd_addr,
    input  frm_vld, frm_rw, frm_addr, frm_data, frm_cnt,
    input  ver_ok, ver_err, short_err, cfg_ok, shd_data
  );

  modport slave (
    input  spi_cs, spi_sdi, spi_sdo, spi_rdy, shd_addr,
    output frm_vld, frm_rw, frm_addr, frm_data, frm_cnt,
    output ver_ok, ver_err, short_err, cfg_ok, shd_data
  );
endinterface

// File: rtl/spi_rdback_mon.sv
// Passive SPI frame decoder with version read-back check and combined cfg_ok.
// Shadow register file is built only when SPI_RB_SHADOW_EN is defined.
module spi_rdback_mon #(
  parameter logic [7:0]  EXP_VER0  = 8'h01,
  parameter logic [7:0]  EXP_VER1  = 8'h02,
  parameter logic [7:0]  VER_MASK  = 8'h03,
  parameter int unsigned SDO_DLY   = 0,
  parameter int unsigned SHD_DEPTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  spi_rdback_mon_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  localparam logic [4:0] WR_LAST  = 5'd15;
  localparam logic [4:0] RD_FIRST = 5'(8 + SDO_DLY);
  localparam logic [4:0] RD_LAST  = 5'(15 + SDO_DLY);

  logic [1:0] state_q, state_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic       armed_q, armed_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] dat_q, dat_d;
  logic       frm_vld_q, frm_vld_d;
  logic       frm_rw_q, frm_rw_d;
  logic [6:0] frm_addr_q, frm_addr_d;
  logic [7:0] frm_data_q, frm_data_d;
  logic [7:0] frm_cnt_q, frm_cnt_d;
  logic       chk0_q, chk0_d;
  logic       chk1_q, chk1_d;
  logic       ver_err_q, ver_err_d;
  logic       short_err_q, short_err_d;
  logic       cfg_ok_q, cfg_ok_d;
  logic       frm_done;
  logic       samp_bit;
  logic       match0, match1;

  // armed blocks decoding of a low period already in progress when reset released
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bus.spi_cs ? 5'd0 : ((bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1);
    armed_d     = armed_q | bus.spi_cs;
    rw_d        = rw_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    frm_vld_d   = 1'b0;
    frm_rw_d    = frm_rw_q;
    frm_addr_d  = frm_addr_q;
    frm_data_d  = frm_data_q;
    frm_cnt_d   = frm_cnt_q;
    chk0_d      = chk0_q;
    chk1_d      = chk1_q;
    ver_err_d   = ver_err_q;
    short_err_d = short_err_q;
    cfg_ok_d    = bus.spi_rdy & chk0_q & chk1_q & ~ver_err_q & ~short_err_q;
    frm_done    = 1'b0;
    samp_bit    = rw_q ? bus.spi_sdo : bus.spi_sdi;

    case (state_q)
      ST_IDLE: begin
        if (!bus.spi_cs && armed_q) begin
          state_d = ST_CMD;
          rw_d    = bus.spi_sdi;
        end
      end
      ST_CMD: begin
        if (bus.spi_cs) begin
          state_d     = ST_IDLE;
          short_err_d = 1'b1;
        end else begin
          addr_d = {addr_q[5:0], bus.spi_sdi};
          if (bit_cnt_q == 5'd7) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.spi_cs) begin
          state_d     = ST_IDLE;
          short_err_d = 1'b1;
        end else begin
          // LSB-first: shifting right leaves the first data bit in bit 0
          if (!rw_q || (bit_cnt_q >= RD_FIRST)) dat_d = {samp_bit, dat_q[7:1]};
          if (bit_cnt_q == (rw_q ? RD_LAST : WR_LAST)) begin
            state_d  = ST_TAIL;
            frm_done = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        if (bus.spi_cs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    match0 = ((dat_d & VER_MASK) == (EXP_VER0 & VER_MASK));
    match1 = ((dat_d & VER_MASK) == (EXP_VER1 & VER_MASK));

    if (frm_done) begin
      frm_vld_d  = 1'b1;
      frm_rw_d   = rw_q;
      frm_addr_d = addr_q;
      frm_data_d = dat_d;
      frm_cnt_d  = (frm_cnt_q == 8'hFF) ? frm_cnt_q : frm_cnt_q + 8'd1;
      if (rw_q && (addr_q == 7'd0)) begin
        chk0_d = match0;
        if (!match0) ver_err_d = 1'b1;
      end
      if (rw_q && (addr_q == 7'd1)) begin
        chk1_d = match1;
        if (!match1) ver_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      armed_q     <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      dat_q       <= 8'd0;
      frm_vld_q   <= 1'b0;
      frm_rw_q    <= 1'b0;
      frm_addr_q  <= 7'd0;
      frm_data_q  <= 8'd0;
      frm_cnt_q   <= 8'd0;
      chk0_q      <= 1'b0;
      chk1_q      <= 1'b0;
      ver_err_q   <= 1'b0;
      short_err_q <= 1'b0;
      cfg_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      armed_q     <= armed_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      frm_vld_q   <= frm_vld_d;
      frm_rw_q    <= frm_rw_d;
      frm_addr_q  <= frm_addr_d;
      frm_data_q  <= frm_data_d;
      frm_cnt_q   <= frm_cnt_d;
      chk0_q      <= chk0_d;
      chk1_q      <= chk1_d;
      ver_err_q   <= ver_err_d;
      short_err_q <= short_err_d;
      cfg_ok_q    <= cfg_ok_d;
    end
  end

  assign bus.frm_vld   = frm_vld_q;
  assign bus.frm_rw    = frm_rw_q;
  assign bus.frm_addr  = frm_addr_q;
  assign bus.frm_data  = frm_data_q;
  assign bus.frm_cnt   = frm_cnt_q;
  assign bus.ver_ok    = chk0_q & chk1_q;
  assign bus.ver_err   = ver_err_q;
  assign bus.short_err = short_err_q;
  assign bus.cfg_ok    = cfg_ok_q;

`ifdef SPI_RB_SHADOW_EN
  logic [7:0] shd_q [SHD_DEPTH];
  logic [7:0] shd_d [SHD_DEPTH];
  logic [7:0] shd_rd;

  always_comb begin
    shd_rd = 8'h00;
    for (int i = 0; i < SHD_DEPTH; i++) begin
      shd_d[i] = shd_q[i];
      if (frm_done && (addr_q == 7'(i))) shd_d[i] = dat_d;
      if ((i < 8) && (bus.shd_addr == 3'(i))) shd_rd = shd_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SHD_DEPTH; i++) begin
      if (!rst_n) shd_q[i] <= 8'h00;
      else        shd_q[i] <= shd_d[i];
    end
  end

  assign bus.shd_data = shd_rd;
`else
  localparam int unsigned UNUSED_SHD_DEPTH = SHD_DEPTH;
  logic [2:0] unused_shd_addr;
  assign unused_shd_addr = bus.shd_addr;
  assign bus.shd_data    = 8'h00;
`endif

endmodule

// File: tb/tb_spi_rdback_mon.sv
// Bench: two monitors (SDO_DLY 0 and 2) share one randomized SPI stimulus and are
// compared every cycle against a bit-collecting frame model.
module tb_spi_rdback_mon;
  localparam int EXP0 = 8'h01;
  localparam int EXP1 = 8'h02;
  localparam int MASK = 8'h03;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo = 1'b0;
  logic       rdy = 1'b0;
  logic [2:0] shd_addr = 3'd0;
  bit         rand_shd = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c_first = 0;
  int vld_cyc[2];
  int nvld[2];

  // model state: per DUT, bits collected in the current low period
  bit        e_vld[2], e_rw[2], e_chk0[2], e_chk1[2], e_verr[2], e_serr[2], e_cfg[2];
  int        e_addr[2], e_data[2], e_cnt[2];
  int        e_shd[2][8];
  bit        m_armed[2], m_low[2], m_on[2], m_done[2];
  int        m_n[2];
  bit [31:0] m_sdi[2], m_sdo[2];

  spi_rdback_mon_if bi0 ();
  spi_rdback_mon_if bi2 ();

  assign bi0.spi_cs = cs;  assign bi0.spi_sdi = sdi; assign bi0.spi_sdo = sdo;
  assign bi0.spi_rdy = rdy; assign bi0.shd_addr = shd_addr;
  assign bi2.spi_cs = cs;  assign bi2.spi_sdi = sdi; assign bi2.spi_sdo = sdo;
  assign bi2.spi_rdy = rdy; assign bi2.shd_addr = shd_addr;

  spi_rdback_mon #(.SDO_DLY(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bi0.slave));
  spi_rdback_mon #(.SDO_DLY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bi2.slave));

  initial forever #5 clk = ~clk;

  task automatic check(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL d%0d %s got=%0h want=%0h t=%0t", i, nm, act, exp, $time);
    end
  endtask

  task automatic frame_done(input int i, input int d);
    bit rw;
    int a, dt;
    bit ok;
    rw = m_sdi[i][0];
    a = 0;
    dt = 0;
    for (int k = 1; k < 8; k++) a = a * 2 + int'(m_sdi[i][k]);
    for (int k = 0; k < 8; k++)
      if (rw ? m_sdo[i][8 + d + k] : m_sdi[i][8 + k]) dt += (1 << k);
    e_vld[i] = 1'b1;
    e_rw[i] = rw;
    e_addr[i] = a;
    e_data[i] = dt;
    e_cnt[i] = (e_cnt[i] == 255) ? 255 : e_cnt[i] + 1;
    if (rw && a == 0) begin
      ok = (((dt ^ EXP0) & MASK) == 0);
      e_chk0[i] = ok;
      if (!ok) e_verr[i] = 1'b1;
    end
    if (rw && a == 1) begin
      ok = (((dt ^ EXP1) & MASK) == 0);
      e_chk1[i] = ok;
      if (!ok) e_verr[i] = 1'b1;
    end
    if (a < 8) e_shd[i][a] = dt;
    m_done[i] = 1'b1;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int d;
      bit cfg_n;
      d = (i == 0) ? 0 : 2;
      cfg_n = rdy & e_chk0[i] & e_chk1[i] & ~e_verr[i] & ~e_serr[i];
      e_vld[i] = 1'b0;
      if (!rst_n) begin
        e_rw[i] = 0; e_addr[i] = 0; e_data[i] = 0; e_cnt[i] = 0;
        e_chk0[i] = 0; e_chk1[i] = 0; e_verr[i] = 0; e_serr[i] = 0; e_cfg[i] = 0;
        for (int k = 0; k < 8; k++) e_shd[i][k] = 0;
        m_armed[i] = 0; m_low[i] = 0; m_on[i] = 0; m_done[i] = 0; m_n[i] = 0;
      end else begin
        e_cfg[i] = cfg_n;
        if (cs) begin
          if (m_on[i] && !m_done[i]) e_serr[i] = 1'b1;
          m_armed[i] = 1; m_low[i] = 0; m_on[i] = 0; m_done[i] = 0; m_n[i] = 0;
        end else begin
          if (!m_low[i]) begin
            m_low[i] = 1'b1;
            m_on[i] = m_armed[i];
          end
          if (m_on[i] && !m_done[i]) begin
            m_sdi[i][m_n[i]] = sdi;
            m_sdo[i][m_n[i]] = sdo;
            m_n[i]++;
            if (m_n[i] == (m_sdi[i][0] ? 16 + d : 16)) frame_done(i, d);
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  task automatic cmp(input int i, input logic vld, input logic rw, input logic [6:0] addr,
                     input logic [7:0] data, input logic [7:0] cnt, input logic vok,
                     input logic verr, input logic serr, input logic cfg, input logic [7:0] shd);
    int exp_shd;
`ifdef SPI_RB_SHADOW_EN
    exp_shd = e_shd[i][shd_addr];
`else
    exp_shd = 0;
`endif
    check(i, "frm_vld", 32'(vld), 32'(e_vld[i]));
    check(i, "frm_rw", 32'(rw), 32'(e_rw[i]));
    check(i, "frm_addr", 32'(addr), e_addr[i]);
    check(i, "frm_data", 32'(data), e_data[i]);
    check(i, "frm_cnt", 32'(cnt), e_cnt[i]);
    check(i, "ver_ok", 32'(vok), 32'(e_chk0[i] & e_chk1[i]));
    check(i, "ver_err", 32'(verr), 32'(e_verr[i]));
    check(i, "short_err", 32'(serr), 32'(e_serr[i]));
    check(i, "cfg_ok", 32'(cfg), 32'(e_cfg[i]));
    check(i, "shd_data", 32'(shd), exp_shd);
    if (vld) begin
      vld_cyc[i] = cyc;
      nvld[i]++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    cmp(0, bi0.frm_vld, bi0.frm_rw, bi0.frm_addr, bi0.frm_data, bi0.frm_cnt,
        bi0.ver_ok, bi0.ver_err, bi0.short_err, bi0.cfg_ok, bi0.shd_data);
    cmp(1, bi2.frm_vld, bi2.frm_rw, bi2.frm_addr, bi2.frm_data, bi2.frm_cnt,
        bi2.ver_ok, bi2.ver_err, bi2.short_err, bi2.cfg_ok, bi2.shd_data);
  end

  task automatic drive(input bit r, input bit c);
    @(negedge clk);
    #1;
    rst_n = r;
    cs = c;
    sdi = 1'($urandom);
    sdo = 1'($urandom);
    if (rand_shd) shd_addr = 3'($urandom);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b1);
  endtask

  task automatic rst();
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    idle(2);
  endtask

  task automatic frame(input bit rw, input bit [6:0] a, input bit [7:0] dt,
                       input int nlow, input int dly, input int nhigh);
    for (int k = 0; k < nlow; k++) begin
      @(negedge clk);
      #1;
      if (k == 0) c_first = cyc + 1;
      cs = 1'b0;
      if (k == 0)                sdi = rw;
      else if (k < 8)            sdi = a[7 - k];
      else if (!rw && k < 16)    sdi = dt[k - 8];
      else                       sdi = 1'($urandom);
      if (rw && k >= 8 + dly && k < 16 + dly) sdo = dt[k - 8 - dly];
      else                                    sdo = 1'($urandom);
      if (rand_shd) shd_addr = 3'($urandom);
    end
    idle(nhigh);
  endtask

  initial begin
    int n0;
    bit rw;
    bit [6:0] a;
    bit [7:0] dt;
    int nlow;
    vld_cyc[0] = 0; vld_cyc[1] = 0; nvld[0] = 0; nvld[1] = 0;
    rst();
    check(0, "rst_cnt", 32'(bi0.frm_cnt), 0);
    check(0, "rst_cfg", 32'(bi0.cfg_ok), 0);
    check(1, "rst_verr", 32'(bi2.ver_err), 0);

    // read 00H returning FD
    frame(1'b1, 7'h00, 8'hFD, 18, 0, 2);
    check(0, "t1_lat", vld_cyc[0] - c_first + 1, 16);
    check(1, "t1_lat", vld_cyc[1] - c_first + 1, 18);
    check(0, "t1_rw", 32'(bi0.frm_rw), 1);
    check(0, "t1_addr", 32'(bi0.frm_addr), 0);
    check(0, "t1_data", 32'(bi0.frm_data), 32'hFD);
    check(0, "t1_verr", 32'(bi0.ver_err), 0);

    // good version reads then rdy
    rst();
    frame(1'b1, 7'h00, 8'h01, 18, 0, 1);
    frame(1'b1, 7'h01, 8'h02, 18, 0, 1);
    rdy = 1'b1;
    idle(2);
    check(0, "t2_vok", 32'(bi0.ver_ok), 1);
    check(0, "t2_cfg", 32'(bi0.cfg_ok), 1);
    check(0, "t2_cnt", 32'(bi0.frm_cnt), 2);

    // bad version read is sticky
    rst();
    frame(1'b1, 7'h00, 8'h01, 18, 0, 1);
    frame(1'b1, 7'h01, 8'h01, 18, 0, 2);
    check(0, "t3_verr", 32'(bi0.ver_err), 1);
    check(0, "t3_cfg", 32'(bi0.cfg_ok), 0);
    frame(1'b1, 7'h01, 8'h02, 18, 0, 2);
    check(0, "t3_verr2", 32'(bi0.ver_err), 1);
    check(0, "t3_vok", 32'(bi0.ver_ok), 1);
    check(0, "t3_cfg2", 32'(bi0.cfg_ok), 0);

    // long write with tail bits
    rst();
    rdy = 1'b0;
    shd_addr = 3'd5;
    n0 = nvld[0];
    frame(1'b0, 7'h05, 8'h01, 350, 0, 2);
    check(0, "t4_nvld", nvld[0] - n0, 1);
    check(0, "t4_rw", 32'(bi0.frm_rw), 0);
    check(0, "t4_addr", 32'(bi0.frm_addr), 5);
    check(0, "t4_data", 32'(bi0.frm_data), 1);
`ifdef SPI_RB_SHADOW_EN
    check(0, "t4_shd", 32'(bi0.shd_data), 1);
`else
    check(0, "t4_shd", 32'(bi0.shd_data), 0);
`endif

    // short frame then a good one
    rst();
    n0 = nvld[0];
    frame(1'b0, 7'h07, 8'hAA, 10, 0, 2);
    check(0, "t5_serr", 32'(bi0.short_err), 1);
    check(0, "t5_cnt", 32'(bi0.frm_cnt), 0);
    check(0, "t5_nvld", nvld[0] - n0, 0);
    frame(1'b0, 7'h04, 8'h08, 16, 0, 2);
    check(0, "t5_addr", 32'(bi0.frm_addr), 4);
    check(0, "t5_data", 32'(bi0.frm_data), 8);
    check(0, "t5_cnt2", 32'(bi0.frm_cnt), 1);

    // delayed sdo and reset mid-frame
    rst();
    frame(1'b1, 7'h00, 8'h01, 18, 2, 2);
    check(1, "t6_data", 32'(bi2.frm_data), 1);
    check(1, "t6_lat", vld_cyc[1] - c_first + 1, 18);
    check(0, "t6_lat", vld_cyc[0] - c_first + 1, 16);
    frame(1'b0, 7'h03, 8'h55, 5, 0, 0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    idle(3);
    check(0, "t6_serr", 32'(bi0.short_err), 0);
    check(1, "t6_serr", 32'(bi2.short_err), 0);
    check(0, "t6_cnt", 32'(bi0.frm_cnt), 0);
    check(1, "t6_data0", 32'(bi2.frm_data), 0);
    frame(1'b0, 7'h02, 8'h33, 16, 0, 2);
    check(0, "t6_addr", 32'(bi0.frm_addr), 2);
    check(0, "t6_wdata", 32'(bi0.frm_data), 8'h33);

    // randomized traffic
    rst();
    rand_shd = 1'b1;
    for (int f = 0; f < 400; f++) begin
      rw = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 9));
      dt = 8'($urandom);
      if (rw && a < 2 && $urandom_range(0, 1) == 1) dt = (dt & 8'hFC) | ((a == 0) ? 8'h01 : 8'h02);
      case ($urandom_range(0, 9))
        0: nlow = $urandom_range(1, 17);
        1: nlow = $urandom_range(19, 40);
        default: nlow = 18;
      endcase
      if ($urandom_range(0, 15) == 0) rdy = ~rdy;
      frame(rw, a, dt, nlow, $urandom_range(0, 1) * 2, $urandom_range(1, 3));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
